// File: rtl/ten_gig_eth_pcs_pma_0_rx_lock_mon_pkg.sv
// ten_gig_eth_pcs_pma_0_rx_lock_mon_pkg
// Shared definitions for the RX lock monitor: FSM state encoding and the
// widths of the retry and lock-loss statistics counters.
// Optional feature macro used by the monitor: RX_LOCK_MON_STATS_EN.
`timescale 1ns/1ps
package ten_gig_eth_pcs_pma_0_rx_lock_mon_pkg;

  // Lock monitor FSM states
  typedef enum logic [2:0] {
    WAIT_RESETDONE,
    WAIT_LOCK,
    QUALIFY,
    LINKED,
    RESET_PULSE
  } lock_state_t;

  // Width of the saturating retry counter
  localparam int RETRY_CNT_W = 8;

  // Width of the saturating lock-loss counter
  localparam int LOSS_CNT_W = 16;

endpackage

// File: rtl/ten_gig_eth_pcs_pma_0_rx_lock_mon_timer.sv
// ten_gig_eth_pcs_pma_0_rx_lock_mon_timer
// Loadable down-counter that flags when the lock timeout has run out.
// Ports:
//   clk     - core clock, rising edge
//   rst_n   - asynchronous active-low reset, reloads the full timeout
//   load    - restart the timeout window on this edge
//   en      - count this edge (only while the monitor is waiting for lock)
//   expired - the edge about to be taken is the last one of the window
`timescale 1ns/1ps
module ten_gig_eth_pcs_pma_0_rx_lock_mon_timer #(
  parameter int CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] count;

  // The loading edge itself is the first cycle of a new window, so a
  // reload stores one less than the full window. Out of reset no edge has
  // been spent yet, so the full window is stored. The counter parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(CYC);
    end else if (load) begin
      count <= W'(CYC - 1);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Expiry is seen while the last edge of the window is being decided.
  assign expired = (count <= W'(1));

endmodule

// File: rtl/ten_gig_eth_pcs_pma_0_rx_lock_monitor.sv
// ten_gig_eth_pcs_pma_0_rx_lock_monitor
// Qualifies synchronized GT RX reset-done and PCS block-lock into a
// debounced link_up, and issues a fixed-width GT RX reset pulse whenever
// lock is not reached within the timeout window.
// Ports:
//   clk              - core clock, rising edge
//   rst_n            - asynchronous active-low reset
//   rxresetdone_sync - GT RX reset done, already in the clk domain
//   block_lock_sync  - PCS block lock, already in the clk domain
//   link_up          - qualified link status (registered)
//   gt_rxreset       - GT RX reset request, active high (registered)
//   retry_cnt        - failed attempts since last link-up, saturating
//   lock_loss_cnt    - LINKED->WAIT_LOCK drops, saturating
//                      (only when RX_LOCK_MON_STATS_EN is defined)
`timescale 1ns/1ps
module ten_gig_eth_pcs_pma_0_rx_lock_monitor
  import ten_gig_eth_pcs_pma_0_rx_lock_mon_pkg::*;
#(
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int QUAL_CYC         = 1024,
  parameter int UNLOCK_CYC       = 16,
  parameter int RST_PULSE_CYC    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxresetdone_sync,
  input  logic                   block_lock_sync,
  output logic                   link_up,
  output logic                   gt_rxreset,
  output logic [RETRY_CNT_W-1:0] retry_cnt
`ifdef RX_LOCK_MON_STATS_EN
  ,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
`endif
);

  localparam int QW = $clog2(QUAL_CYC + 1);
  localparam int LW = $clog2(UNLOCK_CYC + 1);
  localparam int PW = $clog2(RST_PULSE_CYC + 1);

  lock_state_t   state;
  lock_state_t   next_state;
  logic [QW-1:0] qual_cnt;
  logic [QW-1:0] qual_next;
  logic [LW-1:0] low_cnt;
  logic [LW-1:0] low_next;
  logic [PW-1:0] pulse_cnt;
  logic [PW-1:0] pulse_next;
  logic          timer_load;
  logic          timer_en;
  logic          timer_expired;

  // The timeout window only runs while we are still trying to get locked.
  assign timer_en = (state == WAIT_RESETDONE) || (state == WAIT_LOCK) ||
                    (state == QUALIFY);

  ten_gig_eth_pcs_pma_0_rx_lock_mon_timer #(
    .CYC (LOCK_TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state logic. Run-length counters hold the number of samples
  // already taken, so the deciding sample is the one where the held count
  // equals the target minus one. Priorities: qualification success and
  // lock arrival beat expiry; expiry beats a qualification drop; in
  // LINKED, loss of reset-done beats the unlock filter.
  always_comb begin
    next_state = state;
    qual_next  = '0;
    low_next   = '0;
    pulse_next = '0;
    timer_load = 1'b0;
    case (state)
      WAIT_RESETDONE: begin
        if (rxresetdone_sync) begin
          next_state = WAIT_LOCK;
          timer_load = 1'b1;
        end else if (timer_expired) begin
          next_state = RESET_PULSE;
        end
      end
      WAIT_LOCK: begin
        if (block_lock_sync) begin
          qual_next  = QW'(1);
          next_state = (QUAL_CYC <= 1) ? LINKED : QUALIFY;
        end else if (timer_expired) begin
          next_state = RESET_PULSE;
        end
      end
      QUALIFY: begin
        if (block_lock_sync && (qual_cnt >= QW'(QUAL_CYC - 1))) begin
          next_state = LINKED;
        end else if (timer_expired) begin
          next_state = RESET_PULSE;
        end else if (!block_lock_sync) begin
          next_state = WAIT_LOCK;
        end else begin
          qual_next = qual_cnt + QW'(1);
        end
      end
      LINKED: begin
        if (!rxresetdone_sync) begin
          next_state = WAIT_RESETDONE;
          timer_load = 1'b1;
        end else if (!block_lock_sync) begin
          if (low_cnt >= LW'(UNLOCK_CYC - 1)) begin
            next_state = WAIT_LOCK;
            timer_load = 1'b1;
          end else begin
            low_next = low_cnt + LW'(1);
          end
        end
      end
      RESET_PULSE: begin
        if (pulse_cnt >= PW'(RST_PULSE_CYC - 1)) begin
          next_state = WAIT_RESETDONE;
          timer_load = 1'b1;
        end else begin
          pulse_next = pulse_cnt + PW'(1);
        end
      end
      default: begin
        next_state = WAIT_RESETDONE;
        timer_load = 1'b1;
      end
    endcase
  end

  // State, run-length counters and registered outputs. Outputs are taken
  // from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_RESETDONE;
      qual_cnt   <= '0;
      low_cnt    <= '0;
      pulse_cnt  <= '0;
      link_up    <= 1'b0;
      gt_rxreset <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state      <= next_state;
      qual_cnt   <= qual_next;
      low_cnt    <= low_next;
      pulse_cnt  <= pulse_next;
      link_up    <= (next_state == LINKED);
      gt_rxreset <= (next_state == RESET_PULSE);
      if ((next_state == RESET_PULSE) && (state != RESET_PULSE)) begin
        if (retry_cnt != '1) begin
          retry_cnt <= retry_cnt + RETRY_CNT_W'(1);
        end
      end else if ((next_state == LINKED) && (state != LINKED)) begin
        retry_cnt <= '0;
      end
    end
  end

`ifdef RX_LOCK_MON_STATS_EN
  logic unlock_event;

  // Only a filtered block-lock loss counts; reset-done loss does not.
  assign unlock_event = (state == LINKED) && (next_state == WAIT_LOCK);

  // Saturating lock-loss statistics counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
    end else if (unlock_event && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ten_gig_eth_pcs_pma_0_rx_lock_monitor.sv
// tb_ten_gig_eth_pcs_pma_0_rx_lock_monitor
// Self-checking bench for the RX lock monitor. A deadline/run-length
// reference model predicts every output on every cycle; directed
// scenarios add fixed expectations for latencies, pulse spacing,
// saturation and asynchronous reset. Honours RX_LOCK_MON_STATS_EN.
`timescale 1ns/1ps
module tb_ten_gig_eth_pcs_pma_0_rx_lock_monitor;

  localparam int N_TO = 100;
  localparam int Q    = 8;
  localparam int U    = 4;
  localparam int P    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxresetdone_sync = 1'b0;
  logic       block_lock_sync = 1'b0;
  logic       link_up;
  logic       gt_rxreset;
  logic [7:0] retry_cnt;
`ifdef RX_LOCK_MON_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  int total_checks = 0;
  int bad_checks = 0;

  always #5 clk = ~clk;

  ten_gig_eth_pcs_pma_0_rx_lock_monitor #(
    .LOCK_TIMEOUT_CYC (N_TO),
    .QUAL_CYC         (Q),
    .UNLOCK_CYC       (U),
    .RST_PULSE_CYC    (P)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rxresetdone_sync (rxresetdone_sync),
    .block_lock_sync  (block_lock_sync),
    .link_up          (link_up),
    .gt_rxreset       (gt_rxreset),
    .retry_cnt        (retry_cnt)
`ifdef RX_LOCK_MON_STATS_EN
    ,
    .lock_loss_cnt    (lock_loss_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: phases with an absolute expiry edge number, hi/lo
  // run lengths and a pulse end edge.
  typedef enum int {M_NEED_RD, M_HUNT, M_QUAL, M_UP, M_PULSE} mphase_t;

  mphase_t phase = M_NEED_RD;
  int edge_no = 0;
  int deadline = N_TO;
  int pulse_end = 0;
  int hi_run = 0;
  int lo_run = 0;
  int m_retry = 0;
  int m_loss = 0;

  function void model_reset();
    phase    = M_NEED_RD;
    deadline = edge_no + N_TO;
    hi_run   = 0;
    lo_run   = 0;
    m_retry  = 0;
    m_loss   = 0;
  endfunction

  function void arm_timer();
    deadline = edge_no + N_TO - 1;
  endfunction

  function void start_pulse();
    phase     = M_PULSE;
    pulse_end = edge_no + P;
    if (m_retry < 255) m_retry++;
  endfunction

  function void go_up();
    phase   = M_UP;
    lo_run  = 0;
    m_retry = 0;
  endfunction

  function void model_step(input logic rd, input logic bl);
    edge_no++;
    case (phase)
      M_NEED_RD: begin
        if (rd) begin phase = M_HUNT; arm_timer(); end
        else if (edge_no >= deadline) start_pulse();
      end
      M_HUNT: begin
        if (bl) begin
          hi_run = 1;
          if (hi_run >= Q) go_up(); else phase = M_QUAL;
        end else if (edge_no >= deadline) start_pulse();
      end
      M_QUAL: begin
        if (bl && (hi_run + 1 >= Q)) go_up();
        else if (edge_no >= deadline) start_pulse();
        else if (!bl) phase = M_HUNT;
        else hi_run++;
      end
      M_UP: begin
        if (!rd) begin phase = M_NEED_RD; arm_timer(); end
        else if (!bl) begin
          lo_run++;
          if (lo_run >= U) begin
            phase = M_HUNT;
            arm_timer();
            if (m_loss < 65535) m_loss++;
          end
        end else lo_run = 0;
      end
      M_PULSE: begin
        if (edge_no >= pulse_end) begin phase = M_NEED_RD; arm_timer(); end
      end
      default: phase = M_NEED_RD;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(rxresetdone_sync, block_lock_sync);
  end

  // Per-cycle scoreboard against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("sb_link_up", 32'(link_up), 32'(phase == M_UP));
      checkOutput("sb_gt_rxreset", 32'(gt_rxreset), 32'(phase == M_PULSE));
      checkOutput("sb_retry_cnt", 32'(retry_cnt), m_retry);
`ifdef RX_LOCK_MON_STATS_EN
      checkOutput("sb_lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
`endif
    end
  end

  // Drive both inputs for n cycles; returns on a falling edge.
  task automatic applyStimulus(input logic rd, input logic bl, input int n);
    for (int i = 0; i < n; i++) begin
      rxresetdone_sync = rd;
      block_lock_sync  = bl;
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    rxresetdone_sync = 1'b0;
    block_lock_sync  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_link_up", 32'(link_up), 0);
    checkOutput("rst_gt_rxreset", 32'(gt_rxreset), 0);
    checkOutput("rst_retry_cnt", 32'(retry_cnt), 0);
`ifdef RX_LOCK_MON_STATS_EN
    checkOutput("rst_lock_loss_cnt", 32'(lock_loss_cnt), 0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    int   cyc;
    int   first;
    int   more;
    logic prev_gt;
    logic pulse_seen;
    int   rises[$];
    int   falls[$];
    logic rd_bit;
    logic bl_bit;
    int   len;

    @(negedge clk);

    // Normal link-up
    $display("[TB] normal link-up");
    applyReset();
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 5);
    rxresetdone_sync = 1'b1;
    block_lock_sync  = 1'b1;
    first = 0;
    pulse_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (link_up && (first == 0)) first = k;
      pulse_seen = pulse_seen | gt_rxreset;
    end
    checkOutput("norm_link_latency", first, Q);
    checkOutput("norm_retry_cnt", 32'(retry_cnt), 0);
    checkOutput("norm_no_pulse", 32'(pulse_seen), 0);

    // Timeout retry and retry_cnt saturation
    $display("[TB] timeout retry");
    applyReset();
    rxresetdone_sync = 1'b1;
    block_lock_sync  = 1'b0;
    cyc = 0;
    prev_gt = 1'b0;
    while ((retry_cnt != 8'd255) && (cyc < 27000)) begin
      @(negedge clk);
      cyc++;
      if (gt_rxreset && !prev_gt) rises.push_back(cyc);
      if (!gt_rxreset && prev_gt) falls.push_back(cyc);
      prev_gt = gt_rxreset;
    end
    checkOutput("to_pulse_count", rises.size(), 255);
    if ((rises.size() >= 3) && (falls.size() >= 1)) begin
      checkOutput("to_first_expiry", rises[0], N_TO);
      checkOutput("to_pulse_width", falls[0] - rises[0], P);
      checkOutput("to_period_1", rises[1] - rises[0], N_TO + P);
      checkOutput("to_period_2", rises[2] - rises[1], N_TO + P);
    end
    checkOutput("to_retry_sat", 32'(retry_cnt), 255);
    more = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (gt_rxreset && !prev_gt) more++;
      prev_gt = gt_rxreset;
    end
    checkOutput("to_still_pulsing", 32'(more >= 2), 1);
    checkOutput("to_retry_hold", 32'(retry_cnt), 255);

    // Qualification glitch
    $display("[TB] qualification glitch");
    applyReset();
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 5);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("glitch_seven_fresh", 32'(link_up), 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("glitch_eight_fresh", 32'(link_up), 1);

    // Repeated glitches never qualify: timer still expires on schedule
    applyReset();
    first = 0;
    for (int k = 1; k <= 130; k++) begin
      rxresetdone_sync = 1'b1;
      block_lock_sync  = ((k % 6) != 0);
      @(negedge clk);
      if (gt_rxreset && (first == 0)) first = k;
    end
    checkOutput("glitch_expiry_edge", first, N_TO);

    // Loss filtering
    $display("[TB] loss filtering");
    applyReset();
    applyStimulus(1'b1, 1'b1, 12);
    checkOutput("loss_linked", 32'(link_up), 1);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("loss_short_dip", 32'(link_up), 1);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("loss_third_low", 32'(link_up), 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("loss_fourth_low", 32'(link_up), 0);
`ifdef RX_LOCK_MON_STATS_EN
    checkOutput("loss_stat_inc", 32'(lock_loss_cnt), 1);
`endif

    // Reset-done loss while linked
    $display("[TB] resetdone loss");
    applyStimulus(1'b1, 1'b1, 12);
    checkOutput("rdloss_linked", 32'(link_up), 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("rdloss_drop", 32'(link_up), 0);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("rdloss_stays_down", 32'(link_up), 0);
`ifdef RX_LOCK_MON_STATS_EN
    checkOutput("rdloss_stat_same", 32'(lock_loss_cnt), 1);
`endif
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("rdloss_relink_early", 32'(link_up), 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rdloss_relink", 32'(link_up), 1);

    // Asynchronous reset in the middle of a reset pulse
    $display("[TB] reset mid-pulse");
    applyReset();
    applyStimulus(1'b1, 1'b0, 1);
    cyc = 0;
    while (!gt_rxreset && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mid_pulse_seen", 32'(gt_rxreset), 1);
    checkOutput("mid_pulse_retry", 32'(retry_cnt), 1);
    @(negedge clk);
    checkOutput("mid_pulse_second", 32'(gt_rxreset), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_async_gt", 32'(gt_rxreset), 0);
    checkOutput("mid_async_link", 32'(link_up), 0);
    checkOutput("mid_async_retry", 32'(retry_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("mid_restart_wait_rd", 32'(link_up), 0);
    applyStimulus(1'b1, 1'b1, 8);
    checkOutput("mid_restart_early", 32'(link_up), 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("mid_restart_linked", 32'(link_up), 1);

    // Randomized segments checked by the scoreboard
    $display("[TB] random segments");
    for (int s = 0; s < 60; s++) begin
      rd_bit = ($urandom_range(0, 9) != 0);
      bl_bit = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 130))
                                         : int'($urandom_range(1, 10));
      applyStimulus(rd_bit, bl_bit, len);
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
